mem_access_stage: RTL and testbench

Memory-access pipeline stage of the 8-bit MIPS core. Sits between the execute stage and the write-back stage. Performs data-memory loads and stores with a configurable wait-state count, and stalls the upstream stages while an access is in progress. For every retired instruction it registers the value that write-back commits: the ALU result or the loaded word, on mux_ans_dm.

---
 rtl/mem_access_stage.sv | 156 +++++++++++++++
 tb/tb_mem_access_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage of the 8-bit MIPS core.
// It sits between execute and write-back. It performs data-memory loads and
// stores, and each access takes WAIT_CYCLES extra cycles. While an access is
// in progress it stalls execute. For every retired instruction it registers
// the value that write-back commits.
//
// Ports:
//   clk            clock, all state updates on posedge
//   reset          synchronous active-high reset
//   valid_ex       execute presents a valid instruction
//   mem_read       instruction is a load
//   mem_write      instruction is a store (suppressed when mem_read is also set)
//   alu_ans        ALU result; low ADDR_W bits address the data memory
//   store_data     data word for a store
//   rd_ex          destination register index
//   reg_write_ex   instruction writes the register file
//   stall          combinational; execute holds its inputs while high
//   mux_ans_dm     registered write-back value (loaded word or alu_ans)
//   rd_mem         registered destination index
//   reg_write_mem  registered write enable, cleared for stores
//   valid_mem      registered one-cycle pulse per retired instruction
module mem_access_stage #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_ex,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] alu_ans,
  input  logic [DATA_W-1:0] store_data,
  input  logic [2:0]        rd_ex,
  input  logic              reg_write_ex,
  output logic              stall,
  output logic [DATA_W-1:0] mux_ans_dm,
  output logic [2:0]        rd_mem,
  output logic              reg_write_mem,
  output logic              valid_mem
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0]  addr;
  logic               memop;
  logic               is_load;
  logic               is_store;
  logic               complete;
  logic               mem_we;

  // Upper address bits are ignored, so addresses wrap modulo DEPTH.
  assign addr     = alu_ans[ADDR_W-1:0];
  assign memop    = valid_ex & (mem_read | mem_write);
  assign is_load  = valid_ex & mem_read;
  // When a load and a store are both requested, only the load is performed.
  assign is_store = valid_ex & mem_write & ~mem_read;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: cnt counts the remaining stall cycles in WAIT.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (memop && (WAIT_CYCLES != 0)) begin
          state_next = ST_WAIT;
          cnt_next   = CNT_W'(WAIT_CYCLES - 1);
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic: stall and the completion strobe for the current cycle.
  always_comb begin
    stall    = 1'b0;
    complete = 1'b0;
    unique case (state)
      ST_IDLE: begin
        stall    = memop && (WAIT_CYCLES != 0);
        complete = valid_ex && !stall;
      end
      ST_WAIT: begin
        stall    = (cnt != '0);
        complete = (cnt == '0);
      end
      default: begin
        stall    = 1'b0;
        complete = 1'b0;
      end
    endcase
  end

  assign mem_we = complete & is_store;

  // Write-back registers. Results are captured only on a completion edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      mux_ans_dm    <= '0;
      rd_mem        <= '0;
      reg_write_mem <= 1'b0;
      valid_mem     <= 1'b0;
    end else if (complete) begin
      mux_ans_dm    <= is_load ? mem[addr] : alu_ans;
      rd_mem        <= rd_ex;
      reg_write_mem <= reg_write_ex & ~is_store;
      valid_mem     <= 1'b1;
    end else begin
      reg_write_mem <= 1'b0;
      valid_mem     <= 1'b0;
    end
  end

  // Data memory: synchronous write, combinational read. Reset has priority,
  // so an access aborted by reset never writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[addr] <= store_data;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: self-checking bench for mem_access_stage.
// Three instances (WAIT_CYCLES = 0, 2, 3) run concurrently. Each instance is
// compared every cycle against a transaction-level model. The model holds
// the memory as an array and tracks the expected output registers. An
// N-wait access occupies N+1 cycles, and the first N of those cycles stall.
module tb_mem_access_stage;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset        [NI];
  logic       valid_ex     [NI];
  logic       mem_read     [NI];
  logic       mem_write    [NI];
  logic [7:0] alu_ans      [NI];
  logic [7:0] store_data   [NI];
  logic [2:0] rd_ex        [NI];
  logic       reg_write_ex [NI];
  logic       stall        [NI];
  logic [7:0] mux_ans_dm   [NI];
  logic [2:0] rd_mem       [NI];
  logic       reg_write_mem[NI];
  logic       valid_mem    [NI];

  int unsigned wc [NI];

  // Reference model state
  logic [7:0] m_mem   [NI][16];
  logic [7:0] m_mux   [NI];
  logic [2:0] m_rd    [NI];
  logic       m_rwe   [NI];
  logic       m_valid [NI];
  logic       m_stall [NI];
  bit         chk_en    [NI];
  bit         chk_stall [NI];

  int total = 0;
  int bad   = 0;

  mem_access_stage #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset[0]), .valid_ex(valid_ex[0]), .mem_read(mem_read[0]),
    .mem_write(mem_write[0]), .alu_ans(alu_ans[0]), .store_data(store_data[0]),
    .rd_ex(rd_ex[0]), .reg_write_ex(reg_write_ex[0]), .stall(stall[0]),
    .mux_ans_dm(mux_ans_dm[0]), .rd_mem(rd_mem[0]), .reg_write_mem(reg_write_mem[0]),
    .valid_mem(valid_mem[0]));

  mem_access_stage #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(2)) u1 (
    .clk(clk), .reset(reset[1]), .valid_ex(valid_ex[1]), .mem_read(mem_read[1]),
    .mem_write(mem_write[1]), .alu_ans(alu_ans[1]), .store_data(store_data[1]),
    .rd_ex(rd_ex[1]), .reg_write_ex(reg_write_ex[1]), .stall(stall[1]),
    .mux_ans_dm(mux_ans_dm[1]), .rd_mem(rd_mem[1]), .reg_write_mem(reg_write_mem[1]),
    .valid_mem(valid_mem[1]));

  mem_access_stage #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(3)) u2 (
    .clk(clk), .reset(reset[2]), .valid_ex(valid_ex[2]), .mem_read(mem_read[2]),
    .mem_write(mem_write[2]), .alu_ans(alu_ans[2]), .store_data(store_data[2]),
    .rd_ex(rd_ex[2]), .reg_write_ex(reg_write_ex[2]), .stall(stall[2]),
    .mux_ans_dm(mux_ans_dm[2]), .rd_mem(rd_mem[2]), .reg_write_mem(reg_write_mem[2]),
    .valid_mem(valid_mem[2]));

  task automatic cmp(input int g, input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL dut%0d %s: got %h expected %h at %0t", g, nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare, sampled midway between active edges
  always @(negedge clk) begin
    #2;
    for (int g = 0; g < NI; g++) begin
      if (chk_en[g]) begin
        if (chk_stall[g]) cmp(g, "stall", 8'(stall[g]), 8'(m_stall[g]));
        cmp(g, "valid_mem", 8'(valid_mem[g]), 8'(m_valid[g]));
        cmp(g, "reg_write_mem", 8'(reg_write_mem[g]), 8'(m_rwe[g]));
        cmp(g, "mux_ans_dm", mux_ans_dm[g], m_mux[g]);
        cmp(g, "rd_mem", 8'(rd_mem[g]), 8'(rd_mem_exp(g)));
      end
    end
  end

  function automatic logic [2:0] rd_mem_exp(input int g);
    return m_rd[g];
  endfunction

  task automatic clear_model(input int g);
    for (int i = 0; i < 16; i++) m_mem[g][i] = 8'h00;
    m_mux[g]   = 8'h00;
    m_rd[g]    = 3'd0;
    m_rwe[g]   = 1'b0;
    m_valid[g] = 1'b0;
  endtask

  task automatic do_reset(input int g, input int n);
    reset[g] = 1'b1; valid_ex[g] = 1'b0; mem_read[g] = 1'b0; mem_write[g] = 1'b0;
    alu_ans[g] = 8'h00; store_data[g] = 8'h00; rd_ex[g] = 3'd0; reg_write_ex[g] = 1'b0;
    m_stall[g] = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      clear_model(g);
      chk_en[g] = 1'b1;
      chk_stall[g] = 1'b1;
    end
    reset[g] = 1'b0;
  endtask

  // Present one instruction and hold it for as many cycles as it occupies.
  task automatic issue(input int g, input bit v, input bit r, input bit w,
                       input logic [7:0] a, input logic [7:0] sd,
                       input logic [2:0] rdx, input bit rwe);
    int n;
    bit memop;
    logic [3:0] ad;
    logic [7:0] res;
    valid_ex[g] = v; mem_read[g] = r; mem_write[g] = w; alu_ans[g] = a;
    store_data[g] = sd; rd_ex[g] = rdx; reg_write_ex[g] = rwe;
    memop = v && (r || w);
    n = (memop && wc[g] != 0) ? int'(wc[g]) + 1 : 1;
    for (int k = 0; k < n; k++) begin
      m_stall[g] = (k < n - 1);
      @(negedge clk);
      if (k == n - 1 && v) begin
        ad = a[3:0];
        res = (memop && r) ? m_mem[g][ad] : a;
        if (w && !r) m_mem[g][ad] = sd;
        m_mux[g]   = res;
        m_rd[g]    = rdx;
        m_rwe[g]   = rwe && !(w && !r);
        m_valid[g] = 1'b1;
      end else begin
        m_valid[g] = 1'b0;
        m_rwe[g]   = 1'b0;
      end
    end
  endtask

  // Hand-computed expectations right after a retirement
  task automatic lit(input int g, input string nm, input logic [7:0] mux,
                     input bit rwe, input bit vld);
    #1;
    cmp(g, {nm, "_mux"}, mux_ans_dm[g], mux);
    cmp(g, {nm, "_rwe"}, 8'(reg_write_mem[g]), 8'(rwe));
    cmp(g, {nm, "_valid"}, 8'(valid_mem[g]), 8'(vld));
  endtask

  // Store 0xFF to address 2, then reset during the second stall cycle.
  task automatic reset_mid(input int g);
    valid_ex[g] = 1'b1; mem_read[g] = 1'b0; mem_write[g] = 1'b1; alu_ans[g] = 8'h02;
    store_data[g] = 8'hFF; rd_ex[g] = 3'd1; reg_write_ex[g] = 1'b0;
    m_stall[g] = 1'b1;
    @(negedge clk);
    m_valid[g] = 1'b0; m_rwe[g] = 1'b0;
    reset[g] = 1'b1;
    m_stall[g] = 1'b1;
    @(negedge clk);
    clear_model(g);
    reset[g] = 1'b0;
    issue(g, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
  endtask

  task automatic run(input int g);
    bit v, r, w, rwe;
    do_reset(g, 2);
    issue(g, 1, 1, 0, 8'h05, 8'h00, 3'd3, 1);  lit(g, "load_after_reset", 8'h00, 1, 1);
    issue(g, 1, 0, 0, 8'h3C, 8'h00, 3'd2, 1);  lit(g, "alu_pass", 8'h3C, 1, 1);
    cmp(g, "alu_pass_rd", 8'(rd_mem[g]), 8'd2);
    issue(g, 1, 0, 1, 8'h07, 8'hA5, 3'd4, 1);  lit(g, "store_a5", 8'h07, 0, 1);
    issue(g, 1, 1, 0, 8'h07, 8'h00, 3'd5, 1);  lit(g, "load_a5", 8'hA5, 1, 1);
    issue(g, 1, 0, 1, 8'h13, 8'h11, 3'd1, 0);
    issue(g, 1, 1, 0, 8'h03, 8'h00, 3'd1, 1);  lit(g, "wrap_load", 8'h11, 1, 1);
    issue(g, 1, 0, 1, 8'h04, 8'h22, 3'd0, 0);
    issue(g, 1, 1, 1, 8'h04, 8'h99, 3'd6, 1);  lit(g, "rd_wr_both", 8'h22, 1, 1);
    issue(g, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0);  lit(g, "bubble", 8'h22, 0, 0);
    issue(g, 1, 1, 0, 8'h04, 8'h00, 3'd6, 1);  lit(g, "no_write", 8'h22, 1, 1);
    if (wc[g] >= 2) begin
      issue(g, 1, 0, 1, 8'h02, 8'h77, 3'd0, 0);
      reset_mid(g);
      issue(g, 1, 1, 0, 8'h02, 8'h00, 3'd7, 1); lit(g, "after_abort", 8'h00, 1, 1);
    end
    for (int i = 0; i < 250; i++) begin
      v   = ($urandom_range(0, 9) != 0);
      r   = 1'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      rwe = 1'($urandom_range(0, 1));
      issue(g, v, r, w, 8'($urandom), 8'($urandom), 3'($urandom), rwe);
    end
    issue(g, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0);
    issue(g, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0);
    chk_en[g] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    wc[0] = 0; wc[1] = 2; wc[2] = 3;
    for (int g = 0; g < NI; g++) begin
      chk_en[g] = 1'b0; chk_stall[g] = 1'b0; m_stall[g] = 1'b0;
      reset[g] = 1'b1; valid_ex[g] = 1'b0; mem_read[g] = 1'b0; mem_write[g] = 1'b0;
      alu_ans[g] = 8'h00; store_data[g] = 8'h00; rd_ex[g] = 3'd0; reg_write_ex[g] = 1'b0;
      clear_model(g);
    end
    @(negedge clk);
    fork
      run(0);
      run(1);
      run(2);
    join
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
